bcd_to_binary: RTL and testbench

Sequential packed-BCD to unsigned-binary converter. It uses reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more. It is the inverse companion of the binary-to-BCD converter and feeds decimal values entered or received as BCD digits back into binary datapaths. It has one start/data-valid handshake and processes one conversion at a time.

---
 rtl/bcd_to_binary.sv | 179 +++++++++++++++++
 tb/tb_bcd_to_binary.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// bcd_to_binary
//   Sequential packed-BCD to unsigned-binary converter (reverse double-dabble).
//   Each iteration shifts {BCD, result} right by one bit, then subtracts 3 from
//   every BCD digit that is 8 or more. One conversion runs at a time.
//
// Ports
//   i_Clock     : clock, rising edge
//   i_Reset_n   : asynchronous active-low reset
//   i_BCD       : packed BCD input, digit 0 in bits [3:0]; captured at start
//   i_Start     : conversion request, only honoured while idle
//   o_Binary    : registered result, held until the next result
//   o_DV        : one-cycle pulse when o_Binary/o_Error/o_Overflow are updated
//   o_Busy      : high whenever a conversion is in progress
//   o_Error     : captured input contained a digit greater than 9
//   o_Overflow  : converted value did not fit in OUTPUT_WIDTH bits
module bcd_to_binary #(
  parameter int OUTPUT_WIDTH   = 8,
  parameter int DECIMAL_DIGITS = 3
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset_n,
  input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
  input  logic                        i_Start,
  output logic [OUTPUT_WIDTH-1:0]     o_Binary,
  output logic                        o_DV,
  output logic                        o_Busy,
  output logic                        o_Error,
  output logic                        o_Overflow
);

  localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK_SHIFT_INDEX,
    SUB,
    CHECK_DIGIT_INDEX,
    DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [DECIMAL_DIGITS*4-1:0]   bcd_q, bcd_d;
  logic [OUTPUT_WIDTH-1:0]       shift_q, shift_d;
  logic [7:0]                    loop_cnt_q, loop_cnt_d;
  logic [IDX_W-1:0]              digit_idx_q, digit_idx_d;
  logic                          err_q, err_d;
  logic [OUTPUT_WIDTH-1:0]       binary_q, binary_d;
  logic                          dv_q, dv_d;
  logic                          error_q, error_d;
  logic                          overflow_q, overflow_d;

  logic                          bcd_bad;
  logic [3:0]                    cur_digit;

  // Any nibble above 9 makes the incoming word invalid BCD.
  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      if (i_BCD[i*4 +: 4] > 4'd9) begin
        bcd_bad = 1'b1;
      end
    end
  end

  assign cur_digit = bcd_q[int'(digit_idx_q)*4 +: 4];

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    shift_d     = shift_q;
    loop_cnt_d  = loop_cnt_q;
    digit_idx_d = digit_idx_q;
    err_d       = err_q;
    binary_d    = binary_q;
    dv_d        = 1'b0;
    error_d     = error_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (i_Start) begin
          bcd_d       = i_BCD;
          shift_d     = '0;
          loop_cnt_d  = '0;
          digit_idx_d = '0;
          err_d       = bcd_bad;
          state_d     = bcd_bad ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        // {bcd, shift} moves right as one vector.
        shift_d                 = shift_q >> 1;
        shift_d[OUTPUT_WIDTH-1] = bcd_q[0];
        bcd_d                   = bcd_q >> 1;
        state_d                 = CHECK_SHIFT_INDEX;
      end

      CHECK_SHIFT_INDEX: begin
        // The correction pass is not needed after the last shift.
        if (loop_cnt_q == 8'(OUTPUT_WIDTH - 1)) begin
          loop_cnt_d = '0;
          state_d    = DONE;
        end else begin
          loop_cnt_d = loop_cnt_q + 8'd1;
          state_d    = SUB;
        end
      end

      SUB: begin
        if (cur_digit >= 4'd8) begin
          bcd_d[int'(digit_idx_q)*4 +: 4] = cur_digit - 4'd3;
        end
        state_d = CHECK_DIGIT_INDEX;
      end

      CHECK_DIGIT_INDEX: begin
        if (digit_idx_q == IDX_W'(DECIMAL_DIGITS - 1)) begin
          digit_idx_d = '0;
          state_d     = SHIFT;
        end else begin
          digit_idx_d = digit_idx_q + 1'b1;
          state_d     = SUB;
        end
      end

      DONE: begin
        // An invalid input spends one extra cycle here (tracked in the idle
        // loop counter) so its result appears two edges after acceptance.
        if (err_q && (loop_cnt_q == 8'd0)) begin
          loop_cnt_d = 8'd1;
        end else begin
          loop_cnt_d = '0;
          binary_d   = err_q ? '0 : shift_q;
          error_d    = err_q;
          overflow_d = (bcd_q != '0) && !err_q;
          dv_d       = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      shift_q     <= '0;
      loop_cnt_q  <= '0;
      digit_idx_q <= '0;
      err_q       <= 1'b0;
      binary_q    <= '0;
      dv_q        <= 1'b0;
      error_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      shift_q     <= shift_d;
      loop_cnt_q  <= loop_cnt_d;
      digit_idx_q <= digit_idx_d;
      err_q       <= err_d;
      binary_q    <= binary_d;
      dv_q        <= dv_d;
      error_q     <= error_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_Binary   = binary_q;
  assign o_DV       = dv_q;
  assign o_Busy     = (state_q != IDLE);
  assign o_Error    = error_q;
  assign o_Overflow = overflow_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary
//   Directed-vector bench for bcd_to_binary (default parameters). Stimulus
//   pushes the hand-computed result and the cycle it must appear in onto a
//   scoreboard queue; an independent monitor pops and compares on every o_DV.
module tb_bcd_to_binary;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bcd   = '0;
  logic        start = 1'b0;
  logic [7:0]  bin;
  logic        dv, busy, err, ovf;

  always #5 clk = ~clk;

  bcd_to_binary #(.OUTPUT_WIDTH(8), .DECIMAL_DIGITS(3)) dut (
    .i_Clock    (clk),
    .i_Reset_n  (rst_n),
    .i_BCD      (bcd),
    .i_Start    (start),
    .o_Binary   (bin),
    .o_DV       (dv),
    .o_Busy     (busy),
    .o_Error    (err),
    .o_Overflow (ovf)
  );

  typedef struct {
    logic [7:0] bin;
    logic       err;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_cmp    = 0;
  int         n_bad    = 0;
  int         cyc      = 0;
  logic [7:0] last_bin = '0;
  logic       prev_dv  = 1'b0;

  // Rising-edge count; edge N is the N-th rising edge since time zero.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] eb, input logic ee, input logic eo, input int c);
    exp_t e;
    e.bin = eb;
    e.err = ee;
    e.ovf = eo;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dv = 1'b0;
    end else begin
      if (prev_dv) check("dv_one_cycle", {31'd0, dv}, 32'd0);
      if (dv) begin
        if (sb.size() == 0) begin
          check("unexpected_dv", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("binary",       {24'd0, bin},  {24'd0, mon_e.bin});
          check("error",        {31'd0, err},  {31'd0, mon_e.err});
          check("overflow",     {31'd0, ovf},  {31'd0, mon_e.ovf});
          check("dv_cycle",     cyc,           mon_e.cyc);
          check("busy_with_dv", {31'd0, busy}, 32'd0);
          last_bin = mon_e.bin;
        end
      end
      prev_dv = dv;
    end
  end

  // Called at a falling edge; issues one start pulse and checks that the
  // previous result is held and the converter went busy.
  task automatic do_conv(input logic [11:0] v, input logic [7:0] eb,
                         input logic ee, input logic eo, input int lat);
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_before_start", {31'd0, busy}, 32'd0);
    bcd   = v;
    start = 1'b1;
    push_exp(eb, ee, eo, cyc + 1 + lat);
    @(negedge clk);
    start = 1'b0;
    check("hold_at_accept",    {24'd0, bin},  {24'd0, last_bin});
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("result_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_binary"},   {24'd0, bin},  32'd0);
    check({tag, "_dv"},       {31'd0, dv},   32'd0);
    check({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check({tag, "_error"},    {31'd0, err},  32'd0);
    check({tag, "_overflow"}, {31'd0, ovf},  32'd0);
  endtask

  initial begin
    int a0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Plain conversions, in-range and boundary values.
    do_conv(12'h255, 8'hFF, 1'b0, 1'b0, 59); wait_done();
    do_conv(12'h099, 8'h63, 1'b0, 1'b0, 59); wait_done();
    do_conv(12'h000, 8'h00, 1'b0, 1'b0, 59); wait_done();
    // Overflow: result is value mod 256.
    do_conv(12'h256, 8'h00, 1'b0, 1'b1, 59); wait_done();
    do_conv(12'h300, 8'h2C, 1'b0, 1'b1, 59); wait_done();
    // Invalid digit takes the short path; next conversion is clean.
    do_conv(12'h1A2, 8'h00, 1'b1, 1'b0, 2);  wait_done();
    do_conv(12'h042, 8'h2A, 1'b0, 1'b0, 59); wait_done();

    // Inputs toggling while busy must not disturb the captured value.
    do_conv(12'h187, 8'hBB, 1'b0, 1'b0, 59);
    repeat (40) begin
      bcd   = 12'($urandom);
      start = ~start;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done();

    // Start held high: each acceptance lands 60 edges after the previous one.
    while (busy) @(negedge clk);
    a0    = cyc + 1;
    bcd   = 12'h099;
    start = 1'b1;
    push_exp(8'h63, 1'b0, 1'b0, a0 + 59);
    push_exp(8'h7B, 1'b0, 1'b0, a0 + 60 + 59);
    push_exp(8'hFF, 1'b0, 1'b0, a0 + 120 + 59);
    while (cyc < a0 + 120) begin
      @(negedge clk);
      if (cyc == a0 + 59)  bcd = 12'h123;
      if (cyc == a0 + 119) bcd = 12'h255;
    end
    start = 1'b0;
    wait_done();

    // Reset in the middle of a conversion.
    while (busy) @(negedge clk);
    bcd   = 12'h999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    last_bin = 8'h00;
    repeat (80) @(negedge clk);
    do_conv(12'h128, 8'h80, 1'b0, 1'b0, 59); wait_done();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
